lo_edge_reader: RTL

Low-frequency reader front end: the field-generating counterpart to the LF tag-simulation path. Drives the antenna carrier on `pwr_lo`, samples the ADC once per carrier period, slices the envelope with hysteresis to recover tag load modulation, and reports each level change to the ARM as an 8-bit event word over SSP. The ARM decodes protocol timing (Manchester/biphase/FSK) from those words.

---
 rtl/lo_reader_pkg.sv | 28 ++
 rtl/lo_edge_reader_if.sv | 10 +
 rtl/lo_ssp_tx.sv | 104 ++++++++++
 rtl/lo_edge_reader.sv | 124 ++++++++++++
 4 files changed

// File: rtl/lo_reader_pkg.sv
// Shared constants, event-word layout and shifter state type for the LF reader front end.
package lo_reader_pkg;

   localparam int EVT_W = 8;
   localparam int IVL_W = 7;

   localparam logic [7:0]       HI_TH_DEF   = 8'd200;
   localparam logic [7:0]       LO_TH_DEF   = 8'd64;
   localparam logic [IVL_W-1:0] MAX_IVL_DEF = 7'd127;

   // div_cnt value, in the low carrier half, at which the ADC sample is taken
   localparam logic [7:0] STROBE_PH = 8'd7;

   localparam int EVT_LVL_BIT = 7;
   localparam int EVT_IVL_MSB = 6;
   localparam int EVT_IVL_LSB = 0;

   typedef enum logic {SH_IDLE, SH_ACTIVE} sh_state_t;

   function automatic logic [EVT_W-1:0] mk_evt(input logic lvl, input logic [IVL_W-1:0] ivl);
      logic [EVT_W-1:0] w;
      w = '0;
      w[EVT_LVL_BIT] = lvl;
      w[EVT_IVL_MSB:EVT_IVL_LSB] = ivl;
      return w;
   endfunction

endpackage

// File: rtl/lo_edge_reader_if.sv
// SSP link between the reader front end (master, owns the bit clock) and the ARM (slave).
interface lo_edge_reader_if;
   logic ssp_clk;
   logic ssp_frame;
   logic ssp_din;
   logic ssp_dout;

   modport master (output ssp_clk, ssp_frame, ssp_din, input ssp_dout);
   modport slave  (input ssp_clk, ssp_frame, ssp_din, output ssp_dout);
endinterface

// File: rtl/lo_ssp_tx.sv
// Event word serializer: one pending slot plus a shifter, MSB out 1-8 cycles after evt_valid when idle.
// No backpressure: a word arriving while the pending slot stays full is dropped and ovf latches.
module lo_ssp_tx
   import lo_reader_pkg::*;
(
   input  logic             pck0,
   input  logic             rst,
   input  logic             evt_valid,
   input  logic [EVT_W-1:0] evt_word,
   output logic             ssp_clk,
   output logic             ssp_frame,
   output logic             ssp_din,
   output logic             ovf
);

   sh_state_t        state_q, state_d;
   logic [2:0]       sclk_cnt_q, sclk_cnt_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [EVT_W-1:0] pend_q, pend_d;
   logic [EVT_W-1:0] sh_q, sh_d;
   logic             pend_vld_q, pend_vld_d;
   logic             frame_q, frame_d;
   logic             din_q, din_d;
   logic             ovf_q, ovf_d;
   logic             tick;
   logic             load_sh;

   assign tick = (sclk_cnt_q == 3'd7);

   always_comb begin
      sclk_cnt_d = sclk_cnt_q + 3'd1;
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      sh_d       = sh_q;
      frame_d    = frame_q;
      din_d      = din_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      ovf_d      = ovf_q;
      load_sh    = 1'b0;

      if (tick) begin
         // A finished bit 0 hands straight over to the next word, keeping words contiguous
         load_sh = pend_vld_q && (state_q == SH_IDLE || bit_cnt_q == 3'd0);
         frame_d = 1'b0;
         if (load_sh) begin
            state_d   = SH_ACTIVE;
            sh_d      = pend_q;
            bit_cnt_d = 3'd7;
            din_d     = pend_q[EVT_W-1];
            frame_d   = 1'b1;
         end else if (state_q == SH_ACTIVE) begin
            if (bit_cnt_q == 3'd0) begin
               state_d = SH_IDLE;
               din_d   = 1'b0;
            end else begin
               bit_cnt_d = bit_cnt_q - 3'd1;
               din_d     = sh_q[bit_cnt_q - 3'd1];
            end
         end
      end

      if (evt_valid) begin
         if (pend_vld_q && !load_sh) begin
            ovf_d = 1'b1;
         end else begin
            pend_d     = evt_word;
            pend_vld_d = 1'b1;
         end
      end else if (load_sh) begin
         pend_vld_d = 1'b0;
      end
   end

   always_ff @(posedge pck0) begin
      if (rst) begin
         state_q    <= SH_IDLE;
         sclk_cnt_q <= '0;
         bit_cnt_q  <= '0;
         sh_q       <= '0;
         pend_q     <= '0;
         pend_vld_q <= 1'b0;
         frame_q    <= 1'b0;
         din_q      <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         sclk_cnt_q <= sclk_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         sh_q       <= sh_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         frame_q    <= frame_d;
         din_q      <= din_d;
         ovf_q      <= ovf_d;
      end
   end

   assign ssp_clk   = sclk_cnt_q[2];
   assign ssp_frame = frame_q;
   assign ssp_din   = din_q;
   assign ovf       = ovf_q;

endmodule

// File: rtl/lo_edge_reader.sv
// LF reader front end: carrier divider, per-period ADC strobe, hysteresis slicer and interval timer.
// Level-change/timeout words reach lo_ssp_tx on the strobe cycle; excess words are dropped (dbg sticky).
module lo_edge_reader
   import lo_reader_pkg::*;
#(
   parameter logic [7:0]       HI_TH   = HI_TH_DEF,
   parameter logic [7:0]       LO_TH   = LO_TH_DEF,
   parameter logic [IVL_W-1:0] MAX_IVL = MAX_IVL_DEF
) (
   input  logic             pck0,
   input  logic             rst,
   input  logic [7:0]       divisor,
   input  logic [7:0]       adc_d,
   output logic             adc_clk,
   output logic             pwr_lo,
   output logic             pwr_hi,
   output logic             pwr_oe1,
   output logic             pwr_oe2,
   output logic             pwr_oe3,
   output logic             pwr_oe4,
   input  logic             cross_hi,
   input  logic             cross_lo,
   output logic             dbg,
   lo_edge_reader_if.master ssp
);

   logic [7:0]       div_cnt_q, div_cnt_d;
   logic             carrier_q, carrier_d;
   logic             level_q, level_d;
   logic             sat_q, sat_d;
   logic [IVL_W-1:0] ivl_q, ivl_d;
   logic [IVL_W-1:0] ivl_inc;
   logic             slice;
   logic             strobe;
   logic             field_en;
   logic             evt_vld;
   logic [EVT_W-1:0] evt_word;
   logic             unused_cross;

   assign field_en     = ssp.ssp_dout;
   assign strobe       = (div_cnt_q == STROBE_PH) && !carrier_q && (divisor >= STROBE_PH);
   assign unused_cross = cross_hi ^ cross_lo;

   always_comb begin
      div_cnt_d = div_cnt_q + 8'd1;
      carrier_d = carrier_q;
      level_d   = level_q;
      ivl_d     = ivl_q;
      sat_d     = sat_q;
      evt_vld   = 1'b0;
      evt_word  = '0;
      slice     = level_q;
      ivl_inc   = (ivl_q == MAX_IVL) ? MAX_IVL : ivl_q + IVL_W'(1);

      if (div_cnt_q == divisor) begin
         div_cnt_d = '0;
         carrier_d = ~carrier_q;
      end

      if (adc_d >= HI_TH) begin
         slice = 1'b1;
      end else if (adc_d <= LO_TH) begin
         slice = 1'b0;
      end

      if (!field_en) begin
         level_d = 1'b0;
         ivl_d   = '0;
         sat_d   = 1'b0;
      end else if (strobe) begin
         if (slice != level_q) begin
            evt_vld  = 1'b1;
            evt_word = mk_evt(slice, ivl_inc);
            level_d  = slice;
            ivl_d    = '0;
            sat_d    = 1'b0;
         end else begin
            ivl_d = ivl_inc;
            // A single timeout word per run; sat blocks repeats until the next edge
            if (ivl_inc == MAX_IVL && !sat_q) begin
               evt_vld  = 1'b1;
               evt_word = mk_evt(level_q, MAX_IVL);
               sat_d    = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge pck0) begin
      if (rst) begin
         div_cnt_q <= '0;
         carrier_q <= 1'b0;
         level_q   <= 1'b0;
         ivl_q     <= '0;
         sat_q     <= 1'b0;
      end else begin
         div_cnt_q <= div_cnt_d;
         carrier_q <= carrier_d;
         level_q   <= level_d;
         ivl_q     <= ivl_d;
         sat_q     <= sat_d;
      end
   end

   assign adc_clk = ~carrier_q;
   assign pwr_lo  = carrier_q & field_en;
   assign pwr_hi  = 1'b0;
   assign pwr_oe1 = 1'b0;
   assign pwr_oe2 = 1'b0;
   assign pwr_oe3 = 1'b0;
   assign pwr_oe4 = 1'b0;

   lo_ssp_tx u_ssp_tx (
      .pck0      (pck0),
      .rst       (rst),
      .evt_valid (evt_vld),
      .evt_word  (evt_word),
      .ssp_clk   (ssp.ssp_clk),
      .ssp_frame (ssp.ssp_frame),
      .ssp_din   (ssp.ssp_din),
      .ovf       (dbg)
   );

endmodule
